// File: rtl/demux_4out_pkg.sv
// Shared types and helpers for the 1-to-4 packet demultiplexer.
package demux_4out_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    // Packet framing state: IDLE waits for a first beat, PKT has a packet open
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    // One-hot channel decode
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One-entry valid/ready output register holding a beat and its channel.
module demux_out_reg
    import demux_4out_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             last,
    input  logic [CH_W-1:0]  ch,
    input  logic             load,
    input  logic             drain,
    output logic [WIDTH-1:0] q,
    output logic             q_last,
    output logic [CH_W-1:0]  q_ch,
    output logic             q_valid
);

    // Load wins over drain so a same-edge drain+load keeps the entry full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            q_last  <= 1'b0;
            q_ch    <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q       <= d;
            q_last  <= last;
            q_ch    <= ch;
            q_valid <= 1'b1;
        end else if (drain) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_4out.sv
// Registered 1-to-4 packet demultiplexer with per-packet select lock and
// per-channel completed-packet counters.
module demux_4out
    import demux_4out_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic [CH_W-1:0]           sel,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [NUM_CH-1:0]         out_valid,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [NUM_CH*CNT_W-1:0]   pkt_cnt,
    output logic                      busy
);

    state_t            state_q;
    state_t            state_d;
    logic [CH_W-1:0]   route_ch_q;
    logic [CH_W-1:0]   route_ch_d;
    logic [CH_W-1:0]   accept_ch;
    logic              accept;
    logic              drain;

    logic [WIDTH-1:0]  buf_data;
    logic              buf_last;
    logic [CH_W-1:0]   buf_ch;
    logic              buf_valid;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];

    // Handshake: buffer can take a beat when empty or draining this edge
    assign drain    = buf_valid && out_ready[buf_ch];
    assign in_ready = rst_n && (!buf_valid || out_ready[buf_ch]);
    assign accept   = in_valid && in_ready;

    // Next-state and channel selection; sel only matters on a first beat
    always_comb begin
        state_d    = state_q;
        route_ch_d = route_ch_q;
        accept_ch  = route_ch_q;
        case (state_q)
            ST_IDLE: begin
                accept_ch = sel;
                if (accept) begin
                    route_ch_d = sel;
                    if (!in_last) begin
                        state_d = ST_PKT;
                    end
                end
            end
            ST_PKT: begin
                if (accept && in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and locked route register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            route_ch_q <= '0;
        end else begin
            state_q    <= state_d;
            route_ch_q <= route_ch_d;
        end
    end

    // Single output buffer shared by all channels
    demux_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (in_data),
        .last    (in_last),
        .ch      (accept_ch),
        .load    (accept),
        .drain   (drain),
        .q       (buf_data),
        .q_last  (buf_last),
        .q_ch    (buf_ch),
        .q_valid (buf_valid)
    );

    // Count a packet when its last beat leaves on its channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else if (drain && buf_last) begin
            cnt_q[buf_ch] <= cnt_q[buf_ch] + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
        assign pkt_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end

    assign out_valid = buf_valid ? ch_onehot(buf_ch) : '0;
    assign out_data  = buf_data;
    assign out_last  = buf_last;
    assign busy      = (state_q == ST_PKT);

endmodule
